// File: rtl/shift_rot_pipe.sv
// Pipelined barrel shifter/rotator: one register stage per shift-amount bit, valid/ready both sides.
// Optional SHIFTER_ZERO_FLAG_EN adds a registered out_zero flag aligned with out_data.
module shift_rot_pipe #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef SHIFTER_ZERO_FLAG_EN
  ,
  output logic               out_zero
`endif
);

  logic [SHAMT_W-1:0] r_valid;
  logic [WIDTH-1:0]   r_data [SHAMT_W];
  logic [1:0]         r_op   [SHAMT_W];
  // Unconsumed shamt bits, realigned so the next stage's bit sits at the LSB.
  logic [SHAMT_W-1:0] r_rem  [SHAMT_W];

  logic [SHAMT_W-1:0] w_adv;
  logic [WIDTH-1:0]   w_next [SHAMT_W];

  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] d,
                                              input logic [1:0]       op,
                                              input int unsigned      amt,
                                              input logic             en);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = (d << amt) | (d >> (WIDTH - amt));
      2'b01:   r = d << amt;
      2'b10:   r = (d >> amt) | (d << (WIDTH - amt));
      default: r = $signed(d) >>> amt;
    endcase
    return en ? r : d;
  endfunction

  always_comb begin
    w_next[0] = f_step(in_data, in_op, 1, in_shamt[0]);
    for (int k = 1; k < SHAMT_W; k++) begin
      w_next[k] = f_step(r_data[k-1], r_op[k-1], 1 << k, r_rem[k-1][0]);
    end
  end

  // Stage k moves unless it and every stage after it are full and the output is stalled.
  always_comb begin
    w_adv = '0;
    for (int k = 0; k < SHAMT_W; k++) begin
      w_adv[k] = out_ready || !(&(r_valid | SHAMT_W'((1 << k) - 1)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_op[k]    <= '0;
        r_rem[k]   <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= in_valid;
        r_data[0]  <= w_next[0];
        r_op[0]    <= in_op;
        r_rem[0]   <= in_shamt >> 1;
      end
      for (int k = 1; k < SHAMT_W; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_data[k]  <= w_next[k];
          r_op[k]    <= r_op[k-1];
          r_rem[k]   <= r_rem[k-1] >> 1;
        end
      end
    end
  end

`ifdef SHIFTER_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b1;
    end else if (w_adv[SHAMT_W-1]) begin
      r_zero <= ~|w_next[SHAMT_W-1];
    end
  end

  assign out_zero = r_zero;
`endif

  assign in_ready  = w_adv[0];
  assign out_valid = r_valid[SHAMT_W-1];
  assign out_data  = r_data[SHAMT_W-1];

endmodule
